// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef enum logic [2:0] {
        ST_SETUP = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FULL  = 3'd4
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single outstanding IROM reads and
// holds one registered instruction (with PC and PC+4) for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        setup,
    input  logic [31:0] boot_addr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    output logic        fetch_misaligned
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         redirect_take;

    assign target        = word_align(redirect_addr);
    assign redirect_take = !setup && redirect_valid && (state != ST_SETUP);

    // A request goes out from REQ, or from FULL in the same cycle the held
    // instruction is consumed; a redirect that cycle cancels it.
    assign imem_req  = !setup && !redirect_valid &&
                       ((state == ST_REQ) || ((state == ST_FULL) && !stall));
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_SETUP;
            pc               <= RESET_PC;
            instr_valid      <= 1'b0;
            instr_out        <= NOP_WORD;
            instr_pc         <= 32'h0000_0000;
            instr_pc_plus4   <= PC_INCR;
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= redirect_take && (redirect_addr[1:0] != 2'b00);
            if (setup) begin
                state       <= ST_SETUP;
                pc          <= word_align(boot_addr);
                instr_valid <= 1'b0;
                instr_out   <= NOP_WORD;
            end else begin
                case (state)
                    ST_SETUP: state <= ST_REQ;
                    ST_REQ: begin
                        if (redirect_valid) pc <= target;
                        else                state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (redirect_valid) begin
                            pc    <= target;
                            state <= imem_rvalid ? ST_REQ : ST_DRAIN;
                        end else if (imem_rvalid) begin
                            instr_out      <= imem_rdata;
                            instr_pc       <= pc;
                            instr_pc_plus4 <= pc + PC_INCR;
                            instr_valid    <= 1'b1;
                            pc             <= pc + PC_INCR;
                            state          <= ST_FULL;
                        end
                    end
                    // Stale response still in flight: swallow it before refetching.
                    ST_DRAIN: begin
                        if (redirect_valid) pc <= target;
                        if (imem_rvalid)    state <= ST_REQ;
                    end
                    ST_FULL: begin
                        if (redirect_valid) begin
                            instr_valid <= 1'b0;
                            instr_out   <= NOP_WORD;
                            pc          <= target;
                            state       <= ST_REQ;
                        end else if (!stall) begin
                            instr_valid <= 1'b0;
                            instr_out   <= NOP_WORD;
                            state       <= ST_WAIT;
                        end
                    end
                    default: state <= ST_SETUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: IROM model with variable latency and a
// program-order reference model of which instruction should be presented.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        setup;
    logic [31:0] boot_addr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        fetch_misaligned;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .setup(setup), .boot_addr(boot_addr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .instr_valid(instr_valid),
        .fetch_misaligned(fetch_misaligned)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:2], 2'b11, a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // IROM: one response per request, delivered lat cycles later
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;
    int          lat = 1;

    // Reference: next program address, the held instruction, whether the
    // outstanding read is still wanted, and the expected misalign pulse.
    bit          m_setup, have, want, mis;
    logic [31:0] exp_pc, held_pc, held_word;

    task automatic model_reset();
        m_setup = 1'b1; have = 1'b0; want = 1'b0; mis = 1'b0;
        exp_pc = 32'h0; held_pc = 32'h0; held_word = NOP;
        q_addr.delete(); q_due.delete();
        imem_rvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, instr_valid, 1'b0);
        check_eq({tag, "_instr"}, instr_out, NOP);
        check_eq({tag, "_pc"}, instr_pc, 32'h0);
        check_eq({tag, "_pc4"}, instr_pc_plus4, 32'h4);
        check_eq({tag, "_req"}, imem_req, 1'b0);
        check_eq({tag, "_mis"}, fetch_misaligned, 1'b0);
    endtask

    task automatic cycle();
        bit s_rst, s_setup, s_redir, s_stall, s_rvalid, s_req, exp_req, nh;
        logic [31:0] s_tgt, s_boot, s_addr;
        @(negedge clk);
        s_rst = !rst_n; s_setup = setup; s_redir = redirect_valid; s_stall = stall;
        s_rvalid = imem_rvalid; s_req = imem_req; s_tgt = redirect_addr;
        s_boot = boot_addr; s_addr = imem_addr;
        exp_req = rst_n && !setup && !m_setup && !redirect_valid &&
                  (q_addr.size() == 0) && (!have || !stall);
        check_eq("imem_req", imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem_addr, exp_pc);
        check_eq("instr_valid", instr_valid, have);
        if (have) begin
            check_eq("instr_out", instr_out, held_word);
            check_eq("instr_pc", instr_pc, held_pc);
            check_eq("instr_pc_plus4", instr_pc_plus4, held_pc + 32'd4);
        end else begin
            check_eq("nop_bubble", instr_out, NOP);
        end
        check_eq("fetch_misaligned", fetch_misaligned, mis);
        @(posedge clk);
        if (s_rst) begin
            model_reset();
        end else begin
            if (s_rvalid) begin void'(q_addr.pop_front()); void'(q_due.pop_front()); end
            if (s_req) begin q_addr.push_back(s_addr); q_due.push_back(cyc + lat); end
            mis = 1'b0;
            if (s_setup) begin
                m_setup = 1'b1; have = 1'b0; want = 1'b0;
                exp_pc = {s_boot[31:2], 2'b00};
            end else if (m_setup) begin
                m_setup = 1'b0;
            end else begin
                nh = have && s_stall;
                if (s_rvalid && want && !s_redir) begin
                    nh = 1'b1; held_pc = exp_pc; held_word = word_at(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (s_rvalid) want = 1'b0;
                if (s_redir) begin
                    nh = 1'b0; want = 1'b0;
                    exp_pc = {s_tgt[31:2], 2'b00};
                    mis = (s_tgt[1:0] != 2'b00);
                end
                if (s_req) want = 1'b1;
                have = nh;
            end
        end
        #1;
        cyc++;
        imem_rvalid = (q_addr.size() > 0) && (q_due[0] <= cyc);
        imem_rdata  = imem_rvalid ? word_at(q_addr[0]) : $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_for_read(input int budget);
        int k;
        k = 0;
        while (!(q_addr.size() != 0 && want) && k < budget) begin cycle(); k++; end
        check_eq("wait_read_timeout", (k < budget), 1'b1);
    endtask

    task automatic wait_for_full(input int budget);
        int k;
        k = 0;
        while (!have && k < budget) begin cycle(); k++; end
        check_eq("wait_full_timeout", (k < budget), 1'b1);
    endtask

    int setup_cnt;

    initial begin
        setup = 1'b1; boot_addr = 32'h100; stall = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 32'h0; imem_rdata = 32'h0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        run(2);
        rst_n = 1'b1;
        run(2);

        // first fetch from boot address
        setup = 1'b0;
        run(3);
        check_eq("t1_valid", instr_valid, 1'b1);
        check_eq("t1_instr", instr_out, 32'h0050_0093);
        check_eq("t1_pc", instr_pc, 32'h100);
        check_eq("t1_pc4", instr_pc_plus4, 32'h104);

        // straight-line stream, then stalls
        run(7);
        stall = 1'b1; run(5);
        stall = 1'b0; run(4);

        // redirects while stalled in FULL, aligned and misaligned
        wait_for_full(10);
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h200; cycle();
        redirect_valid = 1'b0; run(4);
        redirect_valid = 1'b1; redirect_addr = 32'h203; cycle();
        redirect_valid = 1'b0; run(3);
        stall = 1'b0; run(4);

        // slow IROM, redirect while a read is outstanding
        lat = 3;
        wait_for_read(10);
        redirect_valid = 1'b1; redirect_addr = 32'h300; cycle();
        redirect_valid = 1'b0; run(10);

        // PC wrap
        lat = 1;
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF8; cycle();
        redirect_valid = 1'b0; run(10);

        // setup during an outstanding slow read
        lat = 3;
        wait_for_read(10);
        setup = 1'b1; boot_addr = 32'h40; run(5);
        setup = 1'b0; run(10);

        // asynchronous reset while holding an instruction
        stall = 1'b1;
        wait_for_full(12);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("async_reset");
        setup = 1'b1; boot_addr = 32'h100; stall = 1'b0;
        run(2);
        rst_n = 1'b1; run(2);
        setup = 1'b0;

        // randomized traffic
        setup_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 3);
            if (setup_cnt > 0) begin
                setup_cnt--;
                setup = (setup_cnt != 0);
            end else if ($urandom_range(0, 149) == 0) begin
                setup = 1'b1; setup_cnt = 5;
                boot_addr = $urandom_range(0, 255) << 2;
            end
            stall = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) redirect_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else                           redirect_addr = 32'h0000_1000 + $urandom_range(0, 1023);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
